// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

  // Replicated across the data width to form the read data returned on timeout.
  localparam logic c_timeout_rdata_bit = 1'b0;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/arb_watchdog.sv
// ============================================================================
// Module      : arb_watchdog
// Description : Access-duration counter; flags a timeout after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Saturates at the last value so a stuck enable never wraps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_last)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_timeout = i_en && (r_count == c_last);

endmodule : arb_watchdog

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory between the fetch and data
//               ports, with stall generation and a timeout watchdog.
//               ARB_ROUND_ROBIN_EN selects round-robin instead of DM priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  state_t              r_state;
  state_t              w_state_next;
  grant_t              r_grant;
  grant_t              w_sel;
  logic                w_start;
  logic                w_finish;
  logic                w_in_acc;
  logic                w_timeout;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_err;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t r_last_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= GNT_IF;
    end else if (r_state == DONE) begin
      r_last_grant <= r_grant;
    end
  end

  always_comb begin
    w_sel = GNT_IF;
    if (if_req_i && dm_req_i) begin
      w_sel = (r_last_grant == GNT_IF) ? GNT_DM : GNT_IF;
    end else if (dm_req_i) begin
      w_sel = GNT_DM;
    end
  end
`else
  assign w_sel = dm_req_i ? GNT_DM : GNT_IF;
`endif

  assign w_in_acc = (r_state == IF_ACC) || (r_state == DM_ACC);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_clr     (w_start),
    .i_en      (w_in_acc && !mem_ack_i),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          w_start      = 1'b1;
          w_state_next = (w_sel == GNT_DM) ? DM_ACC : IF_ACC;
        end
      end
      IF_ACC, DM_ACC: begin
        // An ack in the timeout cycle still finishes normally.
        if (mem_ack_i || w_timeout) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant     <= GNT_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_err       <= 1'b0;
    end else if (w_start) begin
      r_grant     <= w_sel;
      r_mem_req   <= 1'b1;
      r_mem_we    <= (w_sel == GNT_DM) && dm_we_i;
      r_mem_addr  <= (w_sel == GNT_DM) ? dm_addr_i : if_addr_i;
      r_mem_wdata <= (w_sel == GNT_DM) ? dm_wdata_i : '0;
    end else if (w_finish) begin
      r_mem_req <= 1'b0;
      if (mem_ack_i) begin
        if (r_grant == GNT_IF) begin
          r_if_rdata <= mem_rdata_i;
        end else if (!r_mem_we) begin
          r_dm_rdata <= mem_rdata_i;
        end
      end else begin
        r_err <= 1'b1;
        if (r_grant == GNT_IF) begin
          r_if_rdata <= {DATA_W{c_timeout_rdata_bit}};
        end else begin
          r_dm_rdata <= {DATA_W{c_timeout_rdata_bit}};
        end
      end
    end
  end

  assign if_ready_o  = (r_state == DONE) && (r_grant == GNT_IF);
  assign dm_ready_o  = (r_state == DONE) && (r_grant == GNT_DM);
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign err_o       = r_err;
  assign stall_o     = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int          TO   = 8;
  localparam logic [31:0] KEY  = 32'h5A5A_0000;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = JUNK;
  logic        stall_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // cycles after first mem_req_o before ack; -1 = never
    logic [31:0] mem_data;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ready_o  (if_ready_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_ready_o  (dm_ready_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_bus();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = JUNK;
  endtask

  // Caller is at a negedge (cycle 0). Drives one request, models the memory,
  // and compares the ready pulse against the scoreboard entry.
  task automatic run_access(input vec_t v, input string tag);
    exp_t        e;
    int          c;
    int          req_cyc;
    int          rcyc;
    bit          got;
    bit          stable_ok;
    bit          stall_ok;
    bit          both;
    bit          act_dm;
    bit          act_err;
    logic [31:0] act_rdata;
    logic [31:0] a0;
    logic [31:0] w0;
    logic        we0;
    if (v.is_dm) begin
      dm_req_i   = 1'b1;
      dm_we_i    = v.we;
      dm_addr_i  = v.addr;
      dm_wdata_i = v.wdata;
    end else begin
      if_req_i  = 1'b1;
      if_addr_i = v.addr;
    end
    e.is_dm = v.is_dm;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.lat   = (v.delay >= 0) ? 2 + v.delay : TO + 1;
    exp_q.push_back(e);
    #1;
    stall_ok  = (stall_o === 1'b1);
    c = 0; req_cyc = -1; rcyc = -1; got = 0; stable_ok = 1; both = 0;
    act_dm = 0; act_err = 0; act_rdata = '0; a0 = '0; w0 = '0; we0 = 1'b0;
    while (!got && c < TO + 10) begin
      @(negedge clk);
      c++;
      mem_ack_i   = 1'b0;
      mem_rdata_i = JUNK;
      if (if_ready_o || dm_ready_o) begin
        got       = 1;
        rcyc      = c;
        act_dm    = dm_ready_o;
        both      = if_ready_o && dm_ready_o;
        act_rdata = dm_ready_o ? dm_rdata_o : if_rdata_o;
        act_err   = err_o;
        if (stall_o !== 1'b0) stall_ok = 0;
      end else begin
        if (stall_o !== 1'b1) stall_ok = 0;
        if (mem_req_o) begin
          if (req_cyc < 0) begin
            req_cyc = c;
            a0 = mem_addr_o; we0 = mem_we_o; w0 = mem_wdata_o;
            chk({tag, ".mem_addr"}, mem_addr_o, v.addr);
            chk({tag, ".mem_we"}, mem_we_o, v.is_dm && v.we);
            if (v.is_dm && v.we) chk({tag, ".mem_wdata"}, mem_wdata_o, v.wdata);
          end else if (mem_addr_o !== a0 || mem_we_o !== we0 || mem_wdata_o !== w0) begin
            stable_ok = 0;
          end
          if (v.delay >= 0 && (c - req_cyc) == v.delay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = v.mem_data;
          end
        end
      end
    end
    chk({tag, ".ready_seen"}, got, 1);
    e = exp_q.pop_front();
    if (got) begin
      chk({tag, ".port"}, act_dm, e.is_dm);
      chk({tag, ".rdata"}, act_rdata, e.rdata);
      chk({tag, ".err"}, act_err, e.err);
      chk({tag, ".latency"}, rcyc, e.lat);
      chk({tag, ".ready_excl"}, both, 0);
    end
    chk({tag, ".req_cycle"}, req_cyc, 1);
    chk({tag, ".fields_stable"}, stable_ok, 1);
    chk({tag, ".stall"}, stall_ok, 1);
    @(negedge clk);
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
  endtask

  initial begin
    bit  ord_q[$];
    bit  exp_dm;
    bit  drop_if;
    bit  drop_dm;
    int  rem_if;
    int  rem_dm;
    int  n;
    int  spurious;
    vec_t v;

    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         1, 32'h8C01_0004, 32'h8C01_0004, 0};
    vecs[1] = '{1, 1, 32'h0000_0040, 32'h1234_5678, 2, 32'hDEAD_BEEF, 32'h0000_0000, 0};
    vecs[2] = '{1, 0, 32'h0000_0044, 32'h0,         0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0};
    vecs[3] = '{1, 1, 32'h0000_0048, 32'hA5A5_A5A5, 3, 32'h1111_1111, 32'hCAFE_F00D, 0};
    vecs[4] = '{0, 0, 32'h0000_0014, 32'h0,         6, 32'h0040_0093, 32'h0040_0093, 0};
    vecs[5] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
    vecs[6] = '{1, 0, 32'h0000_004C, 32'h0,         7, 32'h1357_9BDF, 32'h1357_9BDF, 0};
    vecs[7] = '{0, 0, 32'h0000_0018, 32'h0,         7, 32'h2468_ACE0, 32'h2468_ACE0, 0};

    idle_bus();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.mem_req", mem_req_o, 0);
    chk("rst.mem_we", mem_we_o, 0);
    chk("rst.mem_addr", mem_addr_o, 0);
    chk("rst.mem_wdata", mem_wdata_o, 0);
    chk("rst.if_ready", if_ready_o, 0);
    chk("rst.dm_ready", dm_ready_o, 0);
    chk("rst.err", err_o, 0);
    chk("rst.if_rdata", if_rdata_o, 0);
    chk("rst.dm_rdata", dm_rdata_o, 0);
    chk("rst.stall", stall_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while DM access is outstanding.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80;
    @(negedge clk);
    chk("mrst.mem_req_before", mem_req_o, 1);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("mrst.mem_req_async", mem_req_o, 0);
    chk("mrst.mem_addr", mem_addr_o, 0);
    chk("mrst.dm_rdata", dm_rdata_o, 0);
    chk("mrst.if_rdata", if_rdata_o, 0);
    @(negedge clk);
    dm_req_i = 1'b0;
    rst_i    = 1'b0;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ready_o || dm_ready_o || mem_req_o) spurious++;
    end
    chk("mrst.no_activity", spurious, 0);
    chk("mrst.err", err_o, 0);
    v = '{0, 0, 32'h30, 32'h0, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 0};
    run_access(v, "post_rst_if");

    // Memory never acks.
    v = '{0, 0, 32'h20, 32'h0, -1, 32'h0, 32'h0, 1};
    run_access(v, "timeout");
    chk("timeout.err_sticky", err_o, 1);
    v = '{1, 0, 32'h50, 32'h0, 1, 32'h7777_8888, 32'h7777_8888, 1};
    run_access(v, "after_timeout");
    chk("timeout.err_held", err_o, 1);
    rst_i = 1'b1;
    #1;
    chk("timeout.err_cleared", err_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Simultaneous requests, two accesses per port.
`ifdef ARB_ROUND_ROBIN_EN
    ord_q = '{1, 0, 1, 0};
`else
    ord_q = '{1, 1, 0, 0};
`endif
    rem_if = 2; rem_dm = 2; n = 0; drop_if = 0; drop_dm = 0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = JUNK;
      if (drop_if) begin if_req_i = 1'b0; drop_if = 0; end
      if (drop_dm) begin dm_req_i = 1'b0; drop_dm = 0; end
      if (if_ready_o || dm_ready_o) begin
        chk($sformatf("arb%0d.excl", n), if_ready_o && dm_ready_o, 0);
        exp_dm = ord_q.pop_front();
        chk($sformatf("arb%0d.port", n), dm_ready_o, exp_dm);
        if (dm_ready_o) begin
          chk($sformatf("arb%0d.dm_rdata", n), dm_rdata_o, 32'h200 ^ KEY);
          rem_dm--;
          if (rem_dm == 0) drop_dm = 1;
        end else begin
          chk($sformatf("arb%0d.if_rdata", n), if_rdata_o, 32'h100 ^ KEY);
          rem_if--;
          if (rem_if == 0) drop_if = 1;
        end
        n++;
      end else if (mem_req_o) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_addr_o ^ KEY;
      end
    end
    chk("arb.count", n, 4);
    @(negedge clk);
    idle_bus();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and data-memory port. It sits between the CPU core and the memory model.
- Accepts one request at a time and drives a request/acknowledge transaction to memory.
- Returns read data to the granted port.
- Raises a pipeline stall while any port is waiting.
- A watchdog converts a hung memory access into a sticky error, so the core never deadlocks.

## Interface
- ADDR_W, 32: address width of both ports and the memory.
- DATA_W, 32: data width.
- TIMEOUT, 64: maximum cycles in an access state before abort; must be ≥ 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  instruction-fetch request (read only).
- if_addr_i  in  ADDR_W  fetch address.
- if_ready_o  out  1  one-cycle pulse: if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched word.
- dm_req_i  in  1  data request.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_ready_o  out  1  one-cycle pulse: access done, dm_rdata_o valid for reads.
- dm_rdata_o  out  DATA_W  read data.
- mem_req_o  out  1  memory access request.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ack_i  in  1  memory completion; may be high in the first cycle mem_req_o is high.
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i.
- stall_o  out  1  pipeline freeze.
- err_o  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, IF_ACC, DM_ACC, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: apply the arbitration policy (see Configuration).
  - On grant: register addr, we and wdata into mem_addr_o/mem_we_o/mem_wdata_o, set mem_req_o, go to IF_ACC or DM_ACC.
  - IF grants force mem_we_o = 0.
- **IF_ACC / DM_ACC**
  - mem_req_o and the mem_* fields are held stable.
  - On mem_ack_i = 1: capture mem_rdata_i into the granted port's rdata register, drop mem_req_o, go to DONE.
  - On a write ack, dm_rdata_o retains its previous value.
- **Watchdog**
  - Counter clears on entry to an access state and increments each cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack: set err_o, load rdata with 0, drop mem_req_o, go to DONE.
  - A mem_ack_i arriving in the same cycle as timeout wins; no error is set.
- **DONE**
  - Pulse the granted port's ready_o for exactly one cycle, record last_grant, go to IDLE.
- **Requester rule**
  - Hold req and its fields stable until ready.
  - Deassert req in the cycle after ready, unless a new access is intended.
  - If req is still high in the following IDLE cycle, it is treated as a new request.
- **Outputs**
  - stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o); combinational, no state.
  - rdata outputs hold their last value until overwritten.
- **Reset** (at any time, including mid-access)
  - State returns to IDLE; the access is abandoned without ready.
  - mem_req_o, mem_we_o, ready outputs and err_o go to 0.
  - mem_addr_o, mem_wdata_o and both rdata outputs go to 0.
  - last_grant resets to IF.
  - err_o clears only on reset.

## Timing
- Request sampled in IDLE at edge k: mem_req_o is high from cycle k+1.
- Ack in cycle k+1: ready is high in cycle k+2, and the next grant is possible at the end of cycle k+3.
- Minimum service time is 3 cycles per access; total = 3 + ack delay.
- Timeout path: ready is asserted TIMEOUT+1 cycles after the grant edge.
- Both ports' ready outputs are never high in the same cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On conflict in IDLE, grant the port not in last_grant.
  - Reset value IF means the first conflict grants DM.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, DM always wins conflicts.
  - last_grant is not implemented.
  - IF starvation under continuous DM traffic is accepted.

## Structure
- Shared package arb_pkg holds:
  - state enum (IDLE, IF_ACC, DM_ACC, DONE);
  - grant encoding (GNT_IF = 0, GNT_DM = 1);
  - the timeout read-data constant (0).
- One sub-module, arb_watchdog, holds the counter, clear/enable and the timeout compare, parameterised by TIMEOUT.
- The FSM, registers and stall logic stay in the top module.

## Test plan
- Solo IF read: if_addr_i = 0x10, memory acks 1 cycle after mem_req_o with 0x8C010004 → if_ready_o pulses in cycle 3 with if_rdata_o = 0x8C010004, stall_o high for cycles 0–2.
- DM write: dm_we_i = 1, addr = 0x40, wdata = 0x12345678 → mem_we_o = 1 and fields stable until ack; dm_ready_o pulses once; err_o = 0.
- Simultaneous IF and DM requests held for 4 accesses → DM, IF, DM, IF with ARB_ROUND_ROBIN_EN; DM first and IF only after DM deasserts without it.
- Memory never acks, TIMEOUT = 8 → ready pulses 9 cycles after the grant with rdata = 0, err_o stays 1 until rst_i.
- Ack in the exact timeout cycle → normal data returned, err_o = 0.
- rst_i asserted mid DM_ACC → mem_req_o falls asynchronously, no ready pulse, FSM in IDLE, and the next IF request is served normally.
